step_pulse_gen: RTL and testbench



---
 rtl/step_pulse_gen.sv | 101 ++++++++++
 tb/tb_step_pulse_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - evenly spaced step pulse generator with walk/jog/run/hybrid rates
// Optional STEP_PAUSE_EN adds a pause input that freezes the accumulator and second counter.
module step_pulse_gen #(
    parameter int CLK_HZ = 100000000,
    parameter int ACC_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
`ifdef STEP_PAUSE_EN
    input  logic       pause,
`endif
    output logic       stepPulse,
    output logic       secTick,
    output logic [7:0] curRate,
    output logic [3:0] secIndex
);

    localparam logic [ACC_W-1:0] HZ   = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] LAST = ACC_W'(CLK_HZ - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sec_cnt;
    logic [ACC_W-1:0] sum;
    logic [1:0]       mode_q;
    logic [7:0]       sched_rate;
    logic             hold;
    logic             clear;

    always_comb begin
        sched_rate = 8'd20;
        case (secIndex)
            4'd0:    sched_rate = 8'd20;
            4'd1:    sched_rate = 8'd33;
            4'd2:    sched_rate = 8'd66;
            4'd3:    sched_rate = 8'd27;
            4'd4:    sched_rate = 8'd70;
            4'd5:    sched_rate = 8'd30;
            4'd6:    sched_rate = 8'd19;
            4'd7:    sched_rate = 8'd30;
            4'd8:    sched_rate = 8'd33;
            default: sched_rate = 8'd20;
        endcase
    end

    // Forced to zero only while reset is actually held; otherwise tracks mode.
    always_comb begin
        curRate = 8'd0;
        if (!reset) begin
            case (mode)
                2'b00:   curRate = 8'd32;
                2'b01:   curRate = 8'd64;
                2'b10:   curRate = 8'd128;
                default: curRate = sched_rate;
            endcase
        end
    end

    assign sum   = acc + {{(ACC_W-8){1'b0}}, curRate};
    assign clear = reset || !start || (mode != mode_q);

`ifdef STEP_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        mode_q <= mode;
        if (clear) begin
            acc       <= '0;
            sec_cnt   <= '0;
            secIndex  <= 4'd0;
            stepPulse <= 1'b0;
            secTick   <= 1'b0;
        end else if (hold) begin
            stepPulse <= 1'b0;
            secTick   <= 1'b0;
        end else begin
            if (sum >= HZ) begin
                acc       <= sum - HZ;
                stepPulse <= 1'b1;
            end else begin
                acc       <= sum;
                stepPulse <= 1'b0;
            end
            // acc lands on zero at every wrap, so a rate change here never splits a pulse.
            if (sec_cnt == LAST) begin
                sec_cnt <= '0;
                secTick <= 1'b1;
                if (mode == 2'b11)
                    secIndex <= (secIndex == 4'd8) ? 4'd0 : secIndex + 4'd1;
            end else begin
                sec_cnt <= sec_cnt + ACC_W'(1);
                secTick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - self-checking bench for step_pulse_gen against a per-second arithmetic model
module tb_step_pulse_gen;

    localparam int CLK_HZ = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic       stepPulse;
    logic       secTick;
    logic [7:0] curRate;
    logic [3:0] secIndex;
`ifdef STEP_PAUSE_EN
    logic       pause = 1'b0;
`endif

    always #5 clk = ~clk;

    step_pulse_gen #(.CLK_HZ(CLK_HZ), .ACC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
`ifdef STEP_PAUSE_EN
        .pause     (pause),
`endif
        .stepPulse (stepPulse),
        .secTick   (secTick),
        .curRate   (curRate),
        .secIndex  (secIndex)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int sched [9] = '{20, 33, 66, 27, 70, 30, 19, 30, 33};

    // Model state: edges counted since the last clear, excluding paused edges.
    int         m_n = 0;
    int         m_idx = 0;
    logic       m_pulse = 1'b0;
    logic       m_tick = 1'b0;
    logic [1:0] m_prev_mode = 2'b00;

    int pulses, ticks, first_pulse, last_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rate_of(input logic [1:0] md, input int idx);
        case (md)
            2'b00:   return 32;
            2'b01:   return 64;
            2'b10:   return 128;
            default: return sched[idx];
        endcase
    endfunction

    task automatic step(input int e);
        logic p;
        int   pos, r;
        p = 1'b0;
`ifdef STEP_PAUSE_EN
        p = pause;
`endif
        @(posedge clk);
        if (reset || !start || mode != m_prev_mode) begin
            m_n = 0; m_idx = 0; m_pulse = 1'b0; m_tick = 1'b0;
        end else if (p) begin
            m_pulse = 1'b0; m_tick = 1'b0;
        end else begin
            m_n++;
            pos = (m_n - 1) % CLK_HZ + 1;
            r = rate_of(mode, ((m_n - 1) / CLK_HZ) % 9);
            m_pulse = ((pos * r) / CLK_HZ) != (((pos - 1) * r) / CLK_HZ);
            m_tick = (pos == CLK_HZ);
            m_idx = (mode == 2'b11) ? (m_n / CLK_HZ) % 9 : 0;
        end
        m_prev_mode = mode;
        #1;
        check_eq("stepPulse", {31'd0, stepPulse}, {31'd0, m_pulse});
        check_eq("secTick", {31'd0, secTick}, {31'd0, m_tick});
        check_eq("secIndex", {28'd0, secIndex}, m_idx);
        check_eq("curRate", {24'd0, curRate}, reset ? 0 : rate_of(mode, m_idx));
        if (stepPulse === 1'b1) begin
            pulses++;
            if (first_pulse == 0) first_pulse = e;
        end
        if (secTick === 1'b1) begin
            ticks++;
            last_tick = e;
        end
    endtask

    task automatic run(input int cycles);
        pulses = 0; ticks = 0; first_pulse = 0; last_tick = 0;
        for (int e = 1; e <= cycles; e++) step(e);
    endtask

    initial begin
        int tot, tk;
        reset = 1'b1; start = 1'b0; mode = 2'b00;
        run(2);
        reset = 1'b0;

        // walk
        start = 1'b1;
        run(1000);
        check_eq("walk_first_pulse", first_pulse, 32);
        check_eq("walk_pulses", pulses, 32);
        check_eq("walk_ticks", ticks, 1);
        check_eq("walk_tick_edge", last_tick, 1000);

        // run mode, two seconds
        mode = 2'b10;
        run(1);
        check_eq("mode_change_pulse", pulses, 0);
        run(1000);
        check_eq("run_pulses_s0", pulses, 128);
        check_eq("run_tick_s0", last_tick, 1000);
        run(1000);
        check_eq("run_pulses_s1", pulses, 128);
        check_eq("run_tick_s1", last_tick, 1000);

        // hybrid schedule, ten seconds
        mode = 2'b11;
        run(1);
        tot = 0;
        for (int s = 0; s < 10; s++) begin
            run(1000);
            tot += pulses;
            check_eq("hybrid_sec_pulses", pulses, sched[s % 9]);
            check_eq("hybrid_sec_index", {28'd0, secIndex}, (s + 1) % 9);
        end
        check_eq("hybrid_total", tot, 348);

        // start dropped mid-second
        mode = 2'b00;
        run(1);
        run(499);
        check_eq("walk_by_499", pulses, 15);
        run(1);
        check_eq("walk_edge_500", pulses, 1);
        start = 1'b0;
        run(200);
        check_eq("idle_pulses", pulses, 0);
        start = 1'b1;
        run(40);
        check_eq("restart_first_pulse", first_pulse, 32);

        // reset while running
        mode = 2'b01;
        run(1);
        run(699);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(1000);
        check_eq("jog_after_reset", pulses, 64);
        check_eq("jog_after_reset_tick", last_tick, 1000);

`ifdef STEP_PAUSE_EN
        mode = 2'b00;
        run(1);
        run(300);
        tot = pulses; tk = ticks;
        pause = 1'b1;
        run(300);
        check_eq("pause_pulses", pulses, 0);
        pause = 1'b0;
        run(700);
        check_eq("pause_total", tot + pulses, 32);
        check_eq("pause_tick_edge", last_tick + 600, 1300);
        check_eq("pause_ticks", tk + ticks, 1);
`endif

        // randomized mode/start/reset activity, checked edge-by-edge by the model
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            else reset = 1'b0;
            if ($urandom_range(0, 299) == 0) start = ~start;
            if ($urandom_range(0, 399) == 0) mode = 2'($urandom_range(0, 3));
`ifdef STEP_PAUSE_EN
            if ($urandom_range(0, 199) == 0) pause = ~pause;
`endif
            step(i + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
